// File: rtl/autoenc_pkg.sv
// Shared constants and types for the autoencoder datapath.
//   NEURON_OUT_W : width of one neuron output, fixed point [1,7]
//   NEURON_IN_W  : width of a neuron input, fixed point [9,7]
//   FRAC_W       : fraction bits common to both formats
//   tx_state_e   : states of the layer stream transmitter
package autoenc_pkg;

    localparam int unsigned NEURON_OUT_W = 8;
    localparam int unsigned NEURON_IN_W  = 16;
    localparam int unsigned FRAC_W       = 7;

    typedef enum logic {
        TX_IDLE,
        TX_STREAM
    } tx_state_e;

endpackage

// File: rtl/layer_frame_buf.sv
// Ping-pong frame store for one layer's parallel neuron outputs.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : capture wr_dat into the bank at wr_ptr if it is free
//   wr_dat     : NEURON_NUM values, value k at [k*DAT_W +: DAT_W]
//   rd_release : last beat of the bank at rd_ptr has been read; free it
//   rd_idx     : value index within the bank at rd_ptr
//   rd_dat     : value rd_idx of the bank at rd_ptr (combinational)
//   full       : per-bank occupied flags
//   rd_ptr     : bank currently being read
//   overflow   : sticky, a write found its bank occupied and was dropped
module layer_frame_buf #(
    parameter int unsigned NEURON_NUM = 96,
    parameter int unsigned DAT_W      = 8,
    parameter int unsigned CNT_W      = $clog2(NEURON_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [NEURON_NUM*DAT_W-1:0] wr_dat,
    input  logic                        rd_release,
    input  logic [CNT_W-1:0]            rd_idx,
    output logic [DAT_W-1:0]            rd_dat,
    output logic [1:0]                  full,
    output logic                        rd_ptr,
    output logic                        overflow
);

    logic [DAT_W-1:0] bank_q [2][NEURON_NUM];
    logic [1:0]       full_q, full_d;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic             overflow_q;
    logic             wr_ok;

    // Release is applied before the write test so a bank freed by its last
    // beat can take a new frame on the same edge.
    always_comb begin
        full_d = full_q;
        if (rd_release) begin
            full_d[rd_ptr_q] = 1'b0;
        end
        wr_ok = wr_en && !full_d[wr_ptr_q];
        if (wr_ok) begin
            full_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= 2'b00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_release) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (wr_en && !wr_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Data path: plain registers, no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < int'(NEURON_NUM); k++) begin
                bank_q[wr_ptr_q][k] <= wr_dat[k*DAT_W +: DAT_W];
            end
        end
    end

    assign rd_dat   = bank_q[rd_ptr_q][rd_idx];
    assign full     = full_q;
    assign rd_ptr   = rd_ptr_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/layer_stream_tx.sv
// Serialises one layer's parallel neuron outputs into a contiguous stream
// for the next layer, with ping-pong buffering of whole frames.
//   clk, rst  : clock, synchronous active-high reset
//   in_dat    : NEURON_NUM values, neuron k at [k*DAT_W +: DAT_W]
//   in_valid  : single-cycle pulse, whole in_dat vector valid
//   out_dat   : sign-extended serial value, 0 while out_valid is low
//   out_valid : high for NEURON_NUM successive cycles per frame
//   out_sop   : with beat 0 of a frame
//   out_eop   : with beat NEURON_NUM-1 of a frame
//   overflow  : sticky, a frame was dropped because both banks were full
module layer_stream_tx import autoenc_pkg::*; #(
    parameter int unsigned NEURON_NUM = 96,
    parameter int unsigned DAT_W      = NEURON_OUT_W,
    parameter int unsigned OUT_W      = NEURON_IN_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NEURON_NUM*DAT_W-1:0] in_dat,
    input  logic                        in_valid,
    output logic [OUT_W-1:0]            out_dat,
    output logic                        out_valid,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        overflow
);

    localparam int unsigned CNT_W = $clog2(NEURON_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NEURON_NUM - 1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [DAT_W-1:0] rd_dat;
    logic [1:0]       full;
    logic             rd_ptr;
    logic             last_beat;
    logic             rd_release;

    assign last_beat  = (rd_cnt_q == LAST_BEAT);
    assign rd_release = (state_q == TX_STREAM) && last_beat;

    layer_frame_buf #(
        .NEURON_NUM (NEURON_NUM),
        .DAT_W      (DAT_W),
        .CNT_W      (CNT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (in_valid),
        .wr_dat     (in_dat),
        .rd_release (rd_release),
        .rd_idx     (rd_cnt_q),
        .rd_dat     (rd_dat),
        .full       (full),
        .rd_ptr     (rd_ptr),
        .overflow   (overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            rd_cnt_q  <= '0;
            out_dat   <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            unique case (state_q)
                TX_IDLE: begin
                    out_dat   <= '0;
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b0;
                    rd_cnt_q  <= '0;
                    if (full[rd_ptr]) begin
                        state_q <= TX_STREAM;
                    end
                end
                TX_STREAM: begin
                    // LSB alignment keeps the 7 fraction bits in place.
                    out_dat   <= OUT_W'(signed'(rd_dat));
                    out_valid <= 1'b1;
                    out_sop   <= (rd_cnt_q == '0);
                    out_eop   <= last_beat;
                    if (last_beat) begin
                        rd_cnt_q <= '0;
                        // Other bank already loaded: continue with no gap.
                        if (!full[~rd_ptr]) begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule
